// File: rtl/sram_byte_loader.sv
// sram_byte_loader
// Loads DEPTH bytes from the switches into SRAM words 0..DEPTH-1, one word per
// debounced button press. The sort stage gets a one-cycle load_done after the
// last address is written. The top level uses busy to mux the SRAM pins.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | pins released, waiting for a press; clear rewinds ptr
//   SETUP | CE_N low, address and data on the bus, WE_N still high
//   WRITE | WE_N low for WE_CYCLES cycles
//   HOLD  | WE_N high again, data held one more cycle
//   DONE  | bus released, ptr advances (wraps at DEPTH-1, flags load_done)
module sram_byte_loader #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int DEPTH           = 4,
   parameter int ADDR_W          = 2,
   parameter int WE_CYCLES       = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              button,
   input  logic [7:0]        SW_dq,
   input  logic              clear,
   inout  wire  [15:0]       SRAM_DQ,
   output logic [19:0]       SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UE_N,
   output logic              SRAM_LE_N,
   output logic [ADDR_W-1:0] ptr,
   output logic              busy,
   output logic              load_done
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int WEC_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WEC_W-1:0]  WE_LOAD  = WEC_W'(WE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_WRITE = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [1:0]        sync_q;
   logic              btn_s;
   logic              key_cur;
   logic              key_cur_d;
   logic [DEB_W-1:0]  deb_cnt;
   logic              press;

   logic [WEC_W-1:0]  we_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              dq_oe;

   assign btn_s = sync_q[1];
   // The button is active-low, so a press is the debounced key falling 1 -> 0.
   assign press = key_cur_d & ~key_cur;

   // Two-flop synchroniser followed by the stability-count debouncer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         key_cur   <= 1'b1;
         key_cur_d <= 1'b1;
         deb_cnt   <= '0;
      end else begin
         sync_q    <= {sync_q[0], button};
         key_cur_d <= key_cur;
         if (btn_s != key_cur) begin
            if (deb_cnt == DEB_LAST) begin
               key_cur <= btn_s;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; presses outside IDLE are simply not looked at.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (press) state_nxt = S_SETUP;
         S_SETUP: state_nxt = S_WRITE;
         S_WRITE: if (we_cnt == '0) state_nxt = S_HOLD;
         S_HOLD:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // WE pulse-width down-counter, loaded in SETUP and counted out in WRITE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_cnt <= '0;
      end else if (state == S_SETUP) begin
         we_cnt <= WE_LOAD;
      end else if (state == S_WRITE && we_cnt != '0) begin
         we_cnt <= we_cnt - WEC_W'(1);
      end
   end

   // Address/data capture at the press, pointer advance in DONE, clear in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr    <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (press) begin
                  addr_q <= ptr;
                  data_q <= SW_dq;
               end else if (clear) begin
                  ptr <= '0;
               end
            end
            S_DONE: begin
               if (ptr == PTR_LAST) ptr <= '0;
               else                 ptr <= ptr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Pin controls decoded from the state alone.
   always_comb begin
      SRAM_CE_N = 1'b1;
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      busy      = 1'b1;
      load_done = 1'b0;
      case (state)
         S_IDLE:  busy = 1'b0;
         S_SETUP: begin SRAM_CE_N = 1'b0; dq_oe = 1'b1; end
         S_WRITE: begin SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0; dq_oe = 1'b1; end
         S_HOLD:  begin SRAM_CE_N = 1'b0; dq_oe = 1'b1; end
         S_DONE:  load_done = (ptr == PTR_LAST);
         default: busy = 1'b0;
      endcase
   end

   assign SRAM_DQ   = dq_oe ? {8'h00, data_q} : 16'hzzzz;
   assign SRAM_ADDR = {{(20-ADDR_W){1'b0}}, addr_q};
   assign SRAM_OE_N = 1'b1;
   assign SRAM_UE_N = 1'b1;
   assign SRAM_LE_N = 1'b0;

endmodule

// File: tb/tb_sram_byte_loader.sv
// Directed bench for sram_byte_loader with a short debounce and a small SRAM
// model that latches the low byte on the rising edge of WE_N while CE_N is low.
module tb_sram_byte_loader;

   logic        clk;
   logic        rst_n;
   logic        button;
   logic [7:0]  sw_dq;
   logic        clear;
   wire  [15:0] sram_dq;
   logic [19:0] sram_addr;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        sram_ue_n;
   logic        sram_le_n;
   logic [1:0]  ptr;
   logic        busy;
   logic        load_done;

   sram_byte_loader #(
      .DEBOUNCE_CYCLES (8),
      .DEPTH           (4),
      .ADDR_W          (2),
      .WE_CYCLES       (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .button    (button),
      .SW_dq     (sw_dq),
      .clear     (clear),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (sram_addr),
      .SRAM_CE_N (sram_ce_n),
      .SRAM_OE_N (sram_oe_n),
      .SRAM_WE_N (sram_we_n),
      .SRAM_UE_N (sram_ue_n),
      .SRAM_LE_N (sram_le_n),
      .ptr       (ptr),
      .busy      (busy),
      .load_done (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   logic [7:0]  mem [4];
   int          wr_cnt, ce_low_cnt, we_low_cnt, busy_cnt, ld_cnt, ld_wr_at, key_low_cnt;
   logic [15:0] last_dq;
   logic [19:0] last_addr;
   logic        we_prev = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clr_counts();
      ce_low_cnt = 0; we_low_cnt = 0; busy_cnt = 0; ld_cnt = 0; key_low_cnt = 0;
   endtask

   // SRAM model plus activity counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (!sram_ce_n) ce_low_cnt++;
      if (!sram_we_n) we_low_cnt++;
      if (busy) busy_cnt++;
      if (load_done) begin ld_cnt++; ld_wr_at = wr_cnt; end
      if (dut.key_cur == 1'b0) key_low_cnt++;
      if (!we_prev && sram_we_n && !sram_ce_n) begin
         mem[sram_addr[1:0]] = sram_dq[7:0];
         last_dq   = sram_dq;
         last_addr = sram_addr;
         wr_cnt++;
      end
      we_prev = sram_we_n;
   end

   // Press and release the button; lat is negedges from button-low to busy.
   task automatic press_byte(input logic [7:0] d, output int lat);
      sw_dq  = d;
      button = 1'b0;
      lat    = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) begin lat = i; break; end
      end
      if (lat < 0) chk("press_timeout", 32'd0, 32'd1);
      sw_dq = ~d;
      repeat (20) @(negedge clk);
      button = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      int lat;
      int wr0;
      bit seen;
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      wr_cnt = 0; ld_wr_at = 0; last_dq = '0; last_addr = '0;
      clr_counts();
      rst_n = 1'b0; button = 1'b1; sw_dq = 8'h00; clear = 1'b0;

      // 1: reset state
      repeat (2) @(negedge clk);
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_ue_le", {30'd0, sram_ue_n, sram_le_n}, 32'd2);
      chk("rst_dq_drive", 32'(dut.dq_oe), 32'd0);
      chk("rst_ptr", 32'(ptr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 2: single press of 8'h5A
      clr_counts();
      press_byte(8'h5A, lat);
      chk("t2_latency", 32'(lat), 32'd11);
      chk("t2_writes", 32'(wr_cnt), 32'd1);
      chk("t2_addr", 32'(last_addr), 32'd0);
      chk("t2_dq", 32'(last_dq), 32'h005A);
      chk("t2_we_low", 32'(we_low_cnt), 32'd2);
      chk("t2_ce_low", 32'(ce_low_cnt), 32'd4);
      chk("t2_busy_cycles", 32'(busy_cnt), 32'd5);
      chk("t2_ptr", 32'(ptr), 32'd1);
      chk("t2_load_done", 32'(ld_cnt), 32'd0);

      // 3: clear back to 0, then a full load of four bytes
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("t3_clear_ptr", 32'(ptr), 32'd0);
      clr_counts();
      press_byte(8'h11, lat);
      press_byte(8'h22, lat);
      press_byte(8'h33, lat);
      press_byte(8'h44, lat);
      chk("t3_mem0", 32'(mem[0]), 32'h11);
      chk("t3_mem1", 32'(mem[1]), 32'h22);
      chk("t3_mem2", 32'(mem[2]), 32'h33);
      chk("t3_mem3", 32'(mem[3]), 32'h44);
      chk("t3_writes", 32'(wr_cnt), 32'd5);
      chk("t3_load_done_cycles", 32'(ld_cnt), 32'd1);
      chk("t3_load_done_after", 32'(ld_wr_at), 32'd5);
      chk("t3_ptr_wrap", 32'(ptr), 32'd0);

      // 4: bounce shorter than the debounce window
      clr_counts();
      wr0 = wr_cnt;
      button = 1'b0; repeat (5) @(negedge clk);
      button = 1'b1; repeat (3) @(negedge clk);
      button = 1'b0; repeat (5) @(negedge clk);
      button = 1'b1; repeat (20) @(negedge clk);
      chk("t4_writes", 32'(wr_cnt - wr0), 32'd0);
      chk("t4_busy", 32'(busy_cnt), 32'd0);
      chk("t4_key_low", 32'(key_low_cnt), 32'd0);

      // 5: extra press pulses while busy are dropped
      clr_counts();
      wr0 = wr_cnt;
      sw_dq = 8'h77;
      button = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) begin seen = 1'b1; break; end
      end
      chk("t5_busy_seen", 32'(seen), 32'd1);
      force dut.press = 1'b1;
      repeat (3) @(negedge clk);
      release dut.press;
      repeat (20) @(negedge clk);
      button = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_writes", 32'(wr_cnt - wr0), 32'd1);
      chk("t5_busy_cycles", 32'(busy_cnt), 32'd5);
      chk("t5_mem0", 32'(mem[0]), 32'h77);
      chk("t5_ptr", 32'(ptr), 32'd1);

      // 6: reset during the WRITE of address 2, then clear from ptr=3
      press_byte(8'h99, lat);
      chk("t6_ptr_pre", 32'(ptr), 32'd2);
      wr0 = wr_cnt;
      sw_dq = 8'hAB;
      button = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) begin seen = 1'b1; break; end
      end
      chk("t6_busy_seen", 32'(seen), 32'd1);
      @(negedge clk);
      chk("t6_in_write_we", 32'(sram_we_n), 32'd0);
      chk("t6_in_write_addr", 32'(sram_addr), 32'd2);
      rst_n = 1'b0;
      button = 1'b1;
      @(negedge clk);
      chk("t6_abort_we_n", 32'(sram_we_n), 32'd1);
      chk("t6_abort_ce_n", 32'(sram_ce_n), 32'd1);
      chk("t6_abort_dq_drive", 32'(dut.dq_oe), 32'd0);
      chk("t6_abort_ptr", 32'(ptr), 32'd0);
      chk("t6_abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("t6_mem2_kept", 32'(mem[2]), 32'h33);
      press_byte(8'h01, lat);
      press_byte(8'h02, lat);
      press_byte(8'h03, lat);
      chk("t6_mem2_new", 32'(mem[2]), 32'h03);
      chk("t6_ptr3", 32'(ptr), 32'd3);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("t6_clear_ptr", 32'(ptr), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
